// File: rtl/key_edit_cont_if.sv
// Front-panel bus for key_edit_cont: keys and live values in,
// edit state, shadow registers and commit strobes out.
interface key_edit_cont_if #(
  parameter int NUM_ALARMS = 4
);
  logic [4:0]              KEY;
  logic [17:0]             IN_TIME;
  logic [15:0]             IN_DATE;
  logic [17*NUM_ALARMS-1:0] IN_ALARM;
  logic [1:0]              MODE;
  logic [2:0]              FIELD;
  logic [2:0]              ALARM_SEL;
  logic [17:0]             EDIT_TIME;
  logic [15:0]             EDIT_DATE;
  logic [16:0]             EDIT_ALARM;
  logic                    LOAD_TIME;
  logic                    LOAD_ALARM;
  logic [NUM_ALARMS-1:0]   ALARM_EN;
  logic                    H12;

  modport master (
    output KEY, IN_TIME, IN_DATE, IN_ALARM,
    input  MODE, FIELD, ALARM_SEL,
    input  EDIT_TIME, EDIT_DATE, EDIT_ALARM,
    input  LOAD_TIME, LOAD_ALARM,
    input  ALARM_EN, H12
  );

  modport slave (
    input  KEY, IN_TIME, IN_DATE, IN_ALARM,
    output MODE, FIELD, ALARM_SEL,
    output EDIT_TIME, EDIT_DATE, EDIT_ALARM,
    output LOAD_TIME, LOAD_ALARM,
    output ALARM_EN, H12
  );
endinterface

// File: rtl/key_edit_cont.sv
// Alarm-clock front panel: key debounce/auto-repeat plus the
// view/edit state machine over time, date and alarm shadows.
module key_edit_cont #(
  parameter int NUM_ALARMS   = 4,
  parameter int DEB_CYCLES   = 150,
  parameter int REPEAT_DELAY = 1000,
  parameter int REPEAT_RATE  = 100,
  parameter int TIMEOUT      = 60000
) (
  input  logic           CLK,
  input  logic           RESETN,
  key_edit_cont_if.slave bus
);

  localparam int LIM = DEB_CYCLES + REPEAT_DELAY;
  localparam int HW  = $clog2(LIM + 2);
  localparam int RW  =
    (REPEAT_RATE > 1) ? $clog2(REPEAT_RATE) : 1;
  localparam int IW  = $clog2(TIMEOUT + 1);

  localparam logic [HW-1:0] H_DEB  = HW'(DEB_CYCLES);
  localparam logic [HW-1:0] H_LIM  = HW'(LIM);
  localparam logic [HW-1:0] H_MAX  = HW'(LIM + 1);
  localparam logic [RW-1:0] R_LAST = RW'(REPEAT_RATE - 1);
  localparam logic [IW-1:0] I_TO   = IW'(TIMEOUT);
  localparam logic [2:0]    S_LAST = 3'(NUM_ALARMS - 1);

  localparam int KM = 4;
  localparam int KS = 3;
  localparam int KC = 2;
  localparam int KU = 1;
  localparam int KD = 0;

  typedef enum logic [1:0] {
    M_VT = 2'd0,
    M_VA = 2'd1,
    M_ET = 2'd2,
    M_EA = 2'd3
  } mode_e;

  logic [4:0]            key_q, key_d;
  logic [HW-1:0]         hold_q, hold_d;
  logic [RW-1:0]         rate_q, rate_d;
  logic [4:0]            evt_q, evt_d;
  logic [IW-1:0]         idle_q, idle_d;
  mode_e                 mode_q, mode_d;
  logic [2:0]            field_q, field_d;
  logic [2:0]            sel_q, sel_d;
  logic [17:0]           et_q, et_d;
  logic [15:0]           ed_q, ed_d;
  logic [16:0]           ea_q, ea_d;
  logic                  lt_q, lt_d;
  logic                  la_q, la_d;
  logic [NUM_ALARMS-1:0] en_q, en_d;
  logic                  h12_q, h12_d;

  logic onehot, rep, fire;

  // hold_q counts samples of the current key, saturating
  // just past the repeat threshold; rate_q paces repeats.
  always_comb begin
    key_d  = bus.KEY;
    onehot = (key_q != '0) &&
             ((key_q & (key_q - 5'd1)) == '0);
    rep    = key_q[KU] | key_q[KD];
    if (bus.KEY != key_q)
      hold_d = HW'(1);
    else if (hold_q == H_MAX)
      hold_d = hold_q;
    else
      hold_d = hold_q + HW'(1);
    rate_d = '0;
    if (hold_q >= H_LIM)
      rate_d = (rate_q == R_LAST) ? '0 : rate_q + RW'(1);
    fire = onehot &&
           ((hold_q == H_DEB) ||
            (rep && hold_q >= H_LIM && rate_q == '0));
    evt_d = fire ? key_q : '0;
  end

  logic [17:0] src;
  logic [17:0] tnew;
  logic [15:0] dnew;
  logic [6:0]  fv, lo, hi, nv;

  always_comb begin
    src  = (mode_q == M_EA) ? {1'b0, ea_q} : et_q;
    fv   = '0;
    lo   = '0;
    hi   = '0;
    case (field_q)
      3'd0: begin fv = {2'b0, src[16:12]}; hi = 7'd23; end
      3'd1: begin fv = {1'b0, src[11:6]};  hi = 7'd59; end
      3'd2: begin fv = {1'b0, src[5:0]};   hi = 7'd59; end
      3'd3: begin fv = ed_q[15:9];         hi = 7'd99; end
      3'd4: begin
        fv = {3'b0, ed_q[8:5]};
        lo = 7'd1;
        hi = 7'd12;
      end
      3'd5: begin
        fv = {2'b0, ed_q[4:0]};
        lo = 7'd1;
        hi = 7'd31;
      end
      default: ;
    endcase
    if (evt_q[KU])
      nv = (fv >= hi) ? lo : fv + 7'd1;
    else
      nv = (fv <= lo) ? hi : fv - 7'd1;
    tnew = src;
    dnew = ed_q;
    case (field_q)
      3'd0: tnew[16:12] = nv[4:0];
      3'd1: tnew[11:6]  = nv[5:0];
      3'd2: tnew[5:0]   = nv[5:0];
      3'd3: dnew[15:9]  = nv;
      3'd4: dnew[8:5]   = nv[3:0];
      3'd5: dnew[4:0]   = nv[4:0];
      default: ;
    endcase
  end

  logic                  edit;
  logic [NUM_ALARMS-1:0] sel_mask;
  logic [16:0]           slot;

  always_comb begin
    mode_d   = mode_q;
    field_d  = field_q;
    sel_d    = sel_q;
    et_d     = et_q;
    ed_d     = ed_q;
    ea_d     = ea_q;
    en_d     = en_q;
    h12_d    = h12_q;
    lt_d     = 1'b0;
    la_d     = 1'b0;
    edit     = (mode_q == M_ET) || (mode_q == M_EA);
    sel_mask = NUM_ALARMS'(1) << sel_q;
    slot     = 17'(bus.IN_ALARM >> (17 * sel_q));
    if (!edit || evt_q != '0)
      idle_d = '0;
    else if (idle_q == I_TO)
      idle_d = idle_q;
    else
      idle_d = idle_q + IW'(1);

    if (evt_q != '0) begin
      unique case (mode_q)
        M_VT: begin
          unique case (1'b1)
            evt_q[KM]: begin
              mode_d = M_VA;
              sel_d  = '0;
            end
            evt_q[KS]: begin
              et_d    = bus.IN_TIME;
              ed_d    = bus.IN_DATE;
              field_d = '0;
              mode_d  = M_ET;
            end
            evt_q[KC]: h12_d = ~h12_q;
            default: ;
          endcase
        end
        M_VA: begin
          unique case (1'b1)
            evt_q[KM]: begin
              if (sel_q == S_LAST) begin
                mode_d = M_VT;
                sel_d  = '0;
              end else begin
                sel_d = sel_q + 3'd1;
              end
            end
            evt_q[KS]: begin
              ea_d    = slot;
              field_d = '0;
              mode_d  = M_EA;
            end
            evt_q[KC]: en_d = en_q ^ sel_mask;
            default: ;
          endcase
        end
        M_ET: begin
          unique case (1'b1)
            evt_q[KM]:
              field_d = (field_q == 3'd5) ? '0 : field_q + 3'd1;
            evt_q[KS]: begin
              lt_d   = 1'b1;
              mode_d = M_VT;
            end
            evt_q[KC]: mode_d = M_VT;
            default: begin
              et_d = tnew;
              ed_d = dnew;
            end
          endcase
        end
        M_EA: begin
          unique case (1'b1)
            evt_q[KM]:
              field_d = (field_q == 3'd2) ? '0 : field_q + 3'd1;
            evt_q[KS]: begin
              la_d   = 1'b1;
              en_d   = en_q | sel_mask;
              mode_d = M_VA;
            end
            evt_q[KC]: mode_d = M_VA;
            default: ea_d = tnew[16:0];
          endcase
        end
      endcase
    end else if (edit && idle_q == I_TO) begin
      mode_d = (mode_q == M_ET) ? M_VT : M_VA;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      key_q   <= '0;
      hold_q  <= '0;
      rate_q  <= '0;
      evt_q   <= '0;
      idle_q  <= '0;
      mode_q  <= M_VT;
      field_q <= '0;
      sel_q   <= '0;
      et_q    <= '0;
      ed_q    <= '0;
      ea_q    <= '0;
      lt_q    <= 1'b0;
      la_q    <= 1'b0;
      en_q    <= '0;
      h12_q   <= 1'b0;
    end else begin
      key_q   <= key_d;
      hold_q  <= hold_d;
      rate_q  <= rate_d;
      evt_q   <= evt_d;
      idle_q  <= idle_d;
      mode_q  <= mode_d;
      field_q <= field_d;
      sel_q   <= sel_d;
      et_q    <= et_d;
      ed_q    <= ed_d;
      ea_q    <= ea_d;
      lt_q    <= lt_d;
      la_q    <= la_d;
      en_q    <= en_d;
      h12_q   <= h12_d;
    end
  end

  assign bus.MODE       = mode_q;
  assign bus.FIELD      = field_q;
  assign bus.ALARM_SEL  = sel_q;
  assign bus.EDIT_TIME  = et_q;
  assign bus.EDIT_DATE  = ed_q;
  assign bus.EDIT_ALARM = ea_q;
  assign bus.LOAD_TIME  = lt_q;
  assign bus.LOAD_ALARM = la_q;
  assign bus.ALARM_EN   = en_q;
  assign bus.H12        = h12_q;

endmodule

// File: tb/tb_key_edit_cont.sv
// Randomized scoreboard bench for key_edit_cont against a
// run-length/field-arithmetic reference model.
module tb_key_edit_cont;

  localparam int NA   = 4;
  localparam int DEB  = 4;
  localparam int RD   = 8;
  localparam int RATE = 2;
  localparam int TO   = 60;
  localparam int LIM  = DEB + RD;

  localparam logic [4:0] K_MENU = 5'b10000;
  localparam logic [4:0] K_SET  = 5'b01000;
  localparam logic [4:0] K_CAN  = 5'b00100;
  localparam logic [4:0] K_UP   = 5'b00010;
  localparam logic [4:0] K_DN   = 5'b00001;

  typedef struct packed {
    logic [1:0]    mode;
    logic [2:0]    field;
    logic [2:0]    sel;
    logic [17:0]   et;
    logic [15:0]   ed;
    logic [16:0]   ea;
    logic          lt;
    logic          la;
    logic [NA-1:0] en;
    logic          h12;
  } out_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  key_edit_cont_if #(.NUM_ALARMS(NA)) bus();

  key_edit_cont #(
    .NUM_ALARMS  (NA),
    .DEB_CYCLES  (DEB),
    .REPEAT_DELAY(RD),
    .REPEAT_RATE (RATE),
    .TIMEOUT     (TO)
  ) dut (
    .CLK   (clk),
    .RESETN(rstn),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  out_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   n_cyc   = 0;
  bit   started = 1'b0;
  bit   done    = 1'b0;

  // reference model state
  int            m_mode, m_field, m_sel, m_idle, m_run;
  logic [4:0]    m_prev, m_p1, m_p2;
  logic [17:0]   m_et;
  logic [15:0]   m_ed;
  logic [16:0]   m_ea;
  logic [NA-1:0] m_en;
  logic          m_h12, m_lt, m_la;

  task automatic adjust(input bit up);
    int v[6];
    int lo[6] = '{0, 0, 0, 0, 1, 1};
    int hi[6] = '{23, 59, 59, 99, 12, 31};
    logic [17:0] t;
    int f;
    t    = (m_mode == 3) ? {1'b0, m_ea} : m_et;
    v[0] = int'(t[16:12]);
    v[1] = int'(t[11:6]);
    v[2] = int'(t[5:0]);
    v[3] = int'(m_ed[15:9]);
    v[4] = int'(m_ed[8:5]);
    v[5] = int'(m_ed[4:0]);
    f = m_field;
    if (up) v[f] = (v[f] >= hi[f]) ? lo[f] : v[f] + 1;
    else    v[f] = (v[f] <= lo[f]) ? hi[f] : v[f] - 1;
    t[16:12] = 5'(v[0]);
    t[11:6]  = 6'(v[1]);
    t[5:0]   = 6'(v[2]);
    if (m_mode == 2) begin
      m_et = t;
      m_ed = {7'(v[3]), 4'(v[4]), 5'(v[5])};
    end else begin
      m_ea = t[16:0];
    end
  endtask

  task automatic do_event(input logic [4:0] ev);
    logic [67:0] al;
    case (m_mode)
      0: begin
        if (ev == K_MENU) begin
          m_mode = 1; m_sel = 0;
        end else if (ev == K_SET) begin
          m_et = bus.IN_TIME; m_ed = bus.IN_DATE;
          m_field = 0; m_mode = 2;
        end else if (ev == K_CAN) m_h12 = ~m_h12;
      end
      1: begin
        if (ev == K_MENU) begin
          if (m_sel == NA - 1) begin
            m_mode = 0; m_sel = 0;
          end else m_sel++;
        end else if (ev == K_SET) begin
          al = bus.IN_ALARM;
          m_ea = 17'(al >> (17 * m_sel));
          m_field = 0; m_mode = 3;
        end else if (ev == K_CAN) m_en[m_sel] = ~m_en[m_sel];
      end
      default: begin
        if (ev == K_MENU)
          m_field = (m_field + 1) % ((m_mode == 2) ? 6 : 3);
        else if (ev == K_SET) begin
          if (m_mode == 2) m_lt = 1'b1;
          else begin m_la = 1'b1; m_en[m_sel] = 1'b1; end
          m_mode = m_mode - 2;
        end else if (ev == K_CAN) m_mode = m_mode - 2;
        else adjust(ev == K_UP);
      end
    endcase
  endtask

  // A key's n-th consecutive sample makes an event that lands
  // two edges later.
  task automatic model_edge(input logic rs, input logic [4:0] k);
    logic [4:0] ev, e_new;
    bit rep;
    m_lt = 1'b0;
    m_la = 1'b0;
    if (!rs) begin
      m_mode = 0; m_field = 0; m_sel = 0; m_idle = 0;
      m_run = 0; m_prev = '0; m_p1 = '0; m_p2 = '0;
      m_et = '0; m_ed = '0; m_ea = '0; m_en = '0; m_h12 = 1'b0;
      return;
    end
    m_run  = (k == m_prev) ? m_run + 1 : 1;
    m_prev = k;
    rep    = (k == K_UP) || (k == K_DN);
    e_new  = '0;
    if ($countones(k) == 1 &&
        (m_run == DEB ||
         (rep && m_run >= LIM && (m_run - LIM) % RATE == 0)))
      e_new = k;
    ev   = m_p2;
    m_p2 = m_p1;
    m_p1 = e_new;
    if (ev != '0) begin
      m_idle = 0;
      do_event(ev);
    end else if (m_mode >= 2) begin
      if (m_idle == TO) begin
        m_mode = m_mode - 2; m_idle = 0;
      end else m_idle++;
    end else m_idle = 0;
  endtask

  task automatic drive(input logic rs, input logic [4:0] k,
                       input bit newin);
    out_t e;
    @(posedge clk);
    #1;
    rstn    = rs;
    bus.KEY = k;
    if (newin) begin
      bus.IN_TIME  = 18'($urandom);
      bus.IN_DATE  = 16'($urandom);
      bus.IN_ALARM = 68'({$urandom, $urandom, $urandom});
    end
    model_edge(rs, k);
    e = '{mode: 2'(m_mode), field: 3'(m_field), sel: 3'(m_sel),
          et: m_et, ed: m_ed, ea: m_ea, lt: m_lt, la: m_la,
          en: m_en, h12: m_h12};
    exp_q.push_back(e);
    started = 1'b1;
  endtask

  task automatic seg(input logic [4:0] k, input int len,
                     input bit newin);
    for (int i = 0; i < len; i++)
      drive(1'b1, k, newin && i == 0);
  endtask

  initial begin
    logic [4:0] dk[$];
    int         dl[$];
    logic [4:0] multi[4];
    logic [4:0] k;
    int r, len;
    multi = '{5'b00011, 5'b10001, 5'b01100, 5'b11111};
    bus.KEY      = '0;
    bus.IN_TIME  = {1'b1, 5'd23, 6'd59, 6'd0};
    bus.IN_DATE  = {7'd99, 4'd12, 5'd1};
    bus.IN_ALARM = '0;
    repeat (2) drive(1'b0, '0, 1'b0);
    dk = '{K_MENU, 0, K_MENU, 0, K_MENU, 0, K_MENU, 0,
           K_MENU, 0, K_SET, 0, K_UP, 0, K_MENU, 0, K_DN, 0,
           K_MENU, 0, K_MENU, 0, K_MENU, 0, K_UP, 0, K_DN, 0,
           K_MENU, 0, K_DN, 0, K_SET, 0, K_SET, 0, K_MENU, 0,
           K_MENU, 0, K_UP, 0, K_SET, 0, 5'b00011, 0,
           K_SET, 0};
    dl = '{3, 3, 7, 3, 5, 2, 5, 2,
           5, 2, 5, 2, 5, 2, 5, 2, 5, 2,
           5, 2, 5, 2, 5, 2, 5, 2, 5, 2,
           5, 2, 5, 2, 5, 2, 5, 2, 5, 2,
           5, 2, 30, 3, 5, 2, 20, 2,
           5, 75};
    foreach (dk[i]) seg(dk[i], dl[i], 1'b0);
    seg(K_SET, 5, 1'b0);
    seg('0, 3, 1'b0);
    repeat (2) drive(1'b0, '0, 1'b0);
    for (int s = 0; s < 160; s++) begin
      r = int'($urandom_range(0, 99));
      if (r < 18)      k = K_MENU;
      else if (r < 30) k = K_SET;
      else if (r < 40) k = K_CAN;
      else if (r < 60) k = K_UP;
      else if (r < 75) k = K_DN;
      else if (r < 90) k = '0;
      else             k = multi[$urandom_range(0, 3)];
      len = ($urandom_range(0, 9) == 0) ?
            int'($urandom_range(40, 90)) :
            int'($urandom_range(1, 20));
      if ($urandom_range(0, 99) == 0)
        repeat (2) drive(1'b0, '0, 1'b0);
      seg(k, len, $urandom_range(0, 9) < 3);
    end
    done = 1'b1;
  end

  initial begin
    out_t e, a;
    wait (started);
    @(posedge clk);
    while (!(done && exp_q.size() == 0)) begin
      @(negedge clk);
      n_cyc++;
      n_total++;
      a = '{mode: bus.MODE, field: bus.FIELD, sel: bus.ALARM_SEL,
            et: bus.EDIT_TIME, ed: bus.EDIT_DATE,
            ea: bus.EDIT_ALARM, lt: bus.LOAD_TIME,
            la: bus.LOAD_ALARM, en: bus.ALARM_EN, h12: bus.H12};
      if (exp_q.size() == 0) begin
        $display("FAIL outputs cyc %0d: got %h, no expectation",
                 n_cyc, a);
      end else begin
        e = exp_q.pop_front();
        if (a === e) n_pass++;
        else
          $display("FAIL outputs cyc %0d: got %h exp %h",
                   n_cyc, a, e);
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end

endmodule
